// File: rtl/spi_rx.sv
// spi_rx: SPI mode-0 slave receiver. Bits from an external SPI master are synchronized into
// the CLK domain, assembled into DATA_W-bit words and queued in a small RX FIFO that is read
// through a zero-wait AHB-lite register port (RXDATA, STATUS, CTRL, CLR).
module spi_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          LSB_RESET  = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        HSEL,
    input  logic [1:0]  HTRANS,
    input  logic [3:0]  HADDR,
    input  logic        HWRITE,
    input  logic        HREADY,
    output logic        HREADY_RESP,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    input  logic        SCLK,
    input  logic        SS,
    input  logic        MOSI,
    output logic        IRQ
);

    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] AddrRxData = 2'd0;
    localparam logic [1:0] AddrStatus = 2'd1;
    localparam logic [1:0] AddrCtrl   = 2'd2;
    localparam logic [1:0] AddrClr    = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StPush  = 2'd2
    } state_e;

    // Synchronizers
    logic [2:0] sclk_sync_q;
    logic [1:0] ss_sync_q;
    logic [1:0] mosi_sync_q;
    logic       sclk_rise;
    logic       ss_s;
    logic       mosi_s;

    // Frame FSM
    state_e                state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]     shreg_q, shreg_d;
    logic                  lsb_frame_q, lsb_frame_d;
    logic                  push_req;
    logic                  frame_err_set;

    // AHB data phase
    logic       dp_valid_q;
    logic       dp_write_q;
    logic [1:0] dp_addr_q;
    logic       addr_accept;
    logic       dp_rd;
    logic       dp_wr;
    logic       ctrl_wr;
    logic       clr_wr;
    logic       flush;

    // Control and status
    logic ctrl_en_q;
    logic ctrl_lsb_q;
    logic ctrl_irq_q;
    logic overrun_q;
    logic frame_err_q;
    logic overrun_set;

    // FIFO
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              rx_pop;
    logic              push_ok;
    logic [3:0]        cnt_field;

    logic unused_bits;
    assign unused_bits = ^{HWDATA[31:3], HADDR[1:0], HTRANS[0]};

    assign HREADY_RESP = 1'b1;

    // Two-flop synchronizers; the third SCLK flop provides the previous value for edge detect.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_sync_q <= 3'b000;
            ss_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
            ss_sync_q   <= {ss_sync_q[0], SS};
            mosi_sync_q <= {mosi_sync_q[0], MOSI};
        end
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign ss_s      = ss_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];

    // Frame FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            lsb_frame_q <= LSB_RESET;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            lsb_frame_q <= lsb_frame_d;
        end
    end

    // Frame FSM next state: bit order is latched at every frame start and held for the frame.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        lsb_frame_d   = lsb_frame_q;
        push_req      = 1'b0;
        frame_err_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!ss_s && ctrl_en_q) begin
                    state_d     = StShift;
                    bit_cnt_d   = '0;
                    lsb_frame_d = ctrl_lsb_q;
                end
            end
            StShift: begin
                if (!ctrl_en_q) begin
                    // Disabled mid-frame: silent abort, partial word dropped.
                    state_d = StIdle;
                end else if (ss_s) begin
                    frame_err_set = (bit_cnt_q != '0);
                    state_d       = StIdle;
                end else if (sclk_rise) begin
                    if (lsb_frame_q) begin
                        shreg_d = {mosi_s, shreg_q[DATA_W-1:1]};
                    end else begin
                        shreg_d = {shreg_q[DATA_W-2:0], mosi_s};
                    end
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
                        state_d = StPush;
                    end
                end
            end
            StPush: begin
                push_req = 1'b1;
                if (!ss_s && ctrl_en_q) begin
                    state_d     = StShift;
                    bit_cnt_d   = '0;
                    lsb_frame_d = ctrl_lsb_q;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // AHB address phase capture; the data phase is the following cycle (zero wait states).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 2'd0;
        end else begin
            dp_valid_q <= addr_accept;
            if (addr_accept) begin
                dp_write_q <= HWRITE;
                dp_addr_q  <= HADDR[3:2];
            end
        end
    end

    assign addr_accept = HSEL & HTRANS[1] & HREADY;
    assign dp_rd       = dp_valid_q & ~dp_write_q;
    assign dp_wr       = dp_valid_q & dp_write_q;
    assign ctrl_wr     = dp_wr && (dp_addr_q == AddrCtrl);
    assign clr_wr      = dp_wr && (dp_addr_q == AddrClr);
    assign flush       = clr_wr & HWDATA[2];

    // FIFO status and push/pop decisions; a pop frees the slot a same-cycle push needs.
    always_comb begin
        fifo_full   = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
        fifo_empty  = (fifo_cnt_q == '0);
        rx_pop      = dp_rd && (dp_addr_q == AddrRxData) && !fifo_empty;
        push_ok     = push_req && (!fifo_full || rx_pop) && !flush;
        overrun_set = push_req && fifo_full && !rx_pop;
        cnt_field   = 4'(fifo_cnt_q);
    end

    // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem_q[wr_ptr_q] <= shreg_q;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (rx_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !rx_pop) begin
                fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            end else if (!push_ok && rx_pop) begin
                fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
            end
        end
    end

    // CTRL register and sticky error flags; a new error event wins over a same-cycle clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctrl_en_q   <= 1'b1;
            ctrl_lsb_q  <= LSB_RESET;
            ctrl_irq_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl_en_q  <= HWDATA[0];
                ctrl_lsb_q <= HWDATA[1];
                ctrl_irq_q <= HWDATA[2];
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (clr_wr && HWDATA[0]) begin
                overrun_q <= 1'b0;
            end
            if (frame_err_set) begin
                frame_err_q <= 1'b1;
            end else if (clr_wr && HWDATA[1]) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    // Read data mux: driven only during a read data phase, zero otherwise.
    always_comb begin
        HRDATA = 32'd0;
        if (dp_rd) begin
            unique case (dp_addr_q)
                AddrRxData: begin
                    if (!fifo_empty) begin
                        HRDATA = 32'(fifo_mem_q[rd_ptr_q]);
                    end
                end
                AddrStatus: HRDATA = {25'd0, frame_err_q, overrun_q, fifo_full, cnt_field};
                AddrCtrl:   HRDATA = {29'd0, ctrl_irq_q, ctrl_lsb_q, ctrl_en_q};
                AddrClr:    HRDATA = 32'd0;
                default:    HRDATA = 32'd0;
            endcase
        end
    end

    assign IRQ = (ctrl_irq_q & ~fifo_empty) | overrun_q;

endmodule
